// File: rtl/jtcontra_gfx_busrx.sv
// jtcontra_gfx_busrx
// Responder end of the CPU-style write bus feeding the Contra graphics subsystem.
// Decodes bus cycles into three targets, with priority palette > GFX > config:
//   - 16 kB GFX RAM as two 8 kB banks (0x2000-0x3FFF bank 0, 0x4000-0x5FFF bank 1)
//   - 256-byte palette RAM (pal_cs=1 and 0x0Cxx)
//   - 16 configuration registers (0x00-0x07 -> regs 0-7, 0x60-0x67 -> regs 8-15)
// Anything else is unmapped: writes are dropped, reads return 8'hFF.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   cpu_cen             bus cycle qualifier
//   cpu_addr/cpu_rnw    bus address, 1 = read / 0 = write
//   cpu_dout, pal_cs    write data, palette chip select
//   cpu_din, cpu_ok     registered read data and its one-cycle valid pulse
//   cfg_bus, cfg_upd    flat config registers (reg n at [8n+7:8n]), change pulse
//   vram_addr/vram_data video GFX read port, 1-cycle latency
//   pal_addr/pal_data   video palette read port, 1-cycle latency
//
// Optional build macro JTCONTRA_BUSRX_CHK_EN adds saturating write counters
// (gfx_wr_cnt, pal_wr_cnt, cfg_wr_cnt, miss_cnt) and reports unmapped writes.
// Ports and functional behaviour are the same with or without it.

module jtcontra_gfx_busrx #(
   parameter int unsigned GFX_AW = 14,
   parameter int unsigned PAL_AW = 8,
   parameter int unsigned CFG_N  = 16   // fixed at 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_cen,
   input  logic [15:0]          cpu_addr,
   input  logic                 cpu_rnw,
   input  logic [7:0]           cpu_dout,
   input  logic                 pal_cs,
   output logic [7:0]           cpu_din,
   output logic                 cpu_ok,
   output logic [8*CFG_N-1:0]   cfg_bus,
   output logic                 cfg_upd,
   input  logic [GFX_AW-1:0]    vram_addr,
   output logic [7:0]           vram_data,
   input  logic [PAL_AW-1:0]    pal_addr,
   output logic [7:0]           pal_data
);

   localparam int unsigned GFX_SZ = 1 << GFX_AW;
   localparam int unsigned PAL_SZ = 1 << PAL_AW;

   // Storage
   logic [7:0] gfx_mem [GFX_SZ];
   logic [7:0] pal_mem [PAL_SZ];

   // Registered state
   logic [7:0] cfg_q [CFG_N];
   logic [7:0] cfg_d [CFG_N];
   logic [7:0] cpu_din_q,   cpu_din_d;
   logic       cpu_ok_q,    cpu_ok_d;
   logic       cfg_upd_q,   cfg_upd_d;
   logic [7:0] vram_data_q, vram_data_d;
   logic [7:0] pal_data_q,  pal_data_d;

   // Decode
   logic              wr, rd;
   logic              pal_hit, gfx_hit, cfg_hit;
   logic [GFX_AW-1:0] gfx_idx;
   logic [PAL_AW-1:0] pal_idx;
   logic [3:0]        cfg_idx;

   always_comb begin
      wr      = cpu_cen & ~cpu_rnw;
      rd      = cpu_cen &  cpu_rnw;
      pal_hit = pal_cs && (cpu_addr[15:8] == 8'h0C);
      gfx_hit = !pal_hit &&
                ((cpu_addr[15:13] == 3'b001) || (cpu_addr[15:13] == 3'b010));
      // 6:5 must be 00 or 11, i.e. both bits equal
      cfg_hit = !pal_hit && !gfx_hit &&
                (cpu_addr[15:7] == 9'd0) && (cpu_addr[4:3] == 2'b00) &&
                (cpu_addr[6] == cpu_addr[5]);
      // Bank 0 is 3'b001, bank 1 is 3'b010, so bit 14 alone selects the bank
      gfx_idx = GFX_AW'({cpu_addr[14], cpu_addr[12:0]});
      pal_idx = cpu_addr[PAL_AW-1:0];
      cfg_idx = {cpu_addr[6], cpu_addr[2:0]};
   end

   // Next-state logic
   always_comb begin
      cfg_d     = cfg_q;
      cfg_upd_d = 1'b0;
      if (wr && cfg_hit) begin
         cfg_d[cfg_idx] = cpu_dout;
         cfg_upd_d      = (cpu_dout != cfg_q[cfg_idx]);
      end

      cpu_ok_d  = rd;
      cpu_din_d = cpu_din_q;   // holds between reads
      if (rd) begin
         if (pal_hit)      cpu_din_d = pal_mem[pal_idx];
         else if (gfx_hit) cpu_din_d = gfx_mem[gfx_idx];
         else if (cfg_hit) cpu_din_d = cfg_q[cfg_idx];
         else              cpu_din_d = 8'hFF;
      end

      // Video ports sample the array before this edge's write lands,
      // giving read-before-write on a same-cycle collision.
      vram_data_d = gfx_mem[vram_addr];
      pal_data_d  = pal_mem[pal_addr];
   end

   // RAM arrays carry no reset
   always_ff @(posedge clk) begin
      if (!rst && wr && pal_hit) pal_mem[pal_idx] <= cpu_dout;
      if (!rst && wr && gfx_hit) gfx_mem[gfx_idx] <= cpu_dout;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(CFG_N); i++) cfg_q[i] <= 8'h00;
         cpu_din_q   <= 8'h00;
         cpu_ok_q    <= 1'b0;
         cfg_upd_q   <= 1'b0;
         vram_data_q <= 8'h00;
         pal_data_q  <= 8'h00;
      end else begin
         cfg_q       <= cfg_d;
         cpu_din_q   <= cpu_din_d;
         cpu_ok_q    <= cpu_ok_d;
         cfg_upd_q   <= cfg_upd_d;
         vram_data_q <= vram_data_d;
         pal_data_q  <= pal_data_d;
      end
   end

   // Outputs
   always_comb begin
      cfg_bus = '0;
      for (int i = 0; i < int'(CFG_N); i++) cfg_bus[8*i +: 8] = cfg_q[i];
      cpu_din   = cpu_din_q;
      cpu_ok    = cpu_ok_q;
      cfg_upd   = cfg_upd_q;
      vram_data = vram_data_q;
      pal_data  = pal_data_q;
   end

`ifdef JTCONTRA_BUSRX_CHK_EN
   logic [15:0] gfx_wr_cnt, gfx_wr_cnt_d;
   logic [15:0] pal_wr_cnt, pal_wr_cnt_d;
   logic [15:0] cfg_wr_cnt, cfg_wr_cnt_d;
   logic [15:0] miss_cnt,   miss_cnt_d;
   logic        miss_wr;

   always_comb begin
      miss_wr      = wr && !pal_hit && !gfx_hit && !cfg_hit;
      gfx_wr_cnt_d = gfx_wr_cnt;
      pal_wr_cnt_d = pal_wr_cnt;
      cfg_wr_cnt_d = cfg_wr_cnt;
      miss_cnt_d   = miss_cnt;
      // Saturate at all-ones
      if (wr && gfx_hit && gfx_wr_cnt != 16'hFFFF) gfx_wr_cnt_d = gfx_wr_cnt + 16'd1;
      if (wr && pal_hit && pal_wr_cnt != 16'hFFFF) pal_wr_cnt_d = pal_wr_cnt + 16'd1;
      if (wr && cfg_hit && cfg_wr_cnt != 16'hFFFF) cfg_wr_cnt_d = cfg_wr_cnt + 16'd1;
      if (miss_wr && miss_cnt != 16'hFFFF)         miss_cnt_d   = miss_cnt + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gfx_wr_cnt <= 16'd0;
         pal_wr_cnt <= 16'd0;
         cfg_wr_cnt <= 16'd0;
         miss_cnt   <= 16'd0;
      end else begin
         gfx_wr_cnt <= gfx_wr_cnt_d;
         pal_wr_cnt <= pal_wr_cnt_d;
         cfg_wr_cnt <= cfg_wr_cnt_d;
         miss_cnt   <= miss_cnt_d;
         if (miss_wr) $display("busrx: unmapped write addr=%h data=%h", cpu_addr, cpu_dout);
      end
   end
`endif

endmodule

// File: doc/jtcontra_gfx_busrx.md
Name: jtcontra_gfx_busrx

Overview:
- Responder end of the CPU-style write bus that drives the Contra graphics subsystem.
- Decodes cpu_addr/cpu_rnw/cpu_dout/pal_cs bus cycles into three targets:
  - 16 kB GFX RAM, two 8 kB banks
  - 256-byte palette RAM
  - 16 graphics configuration registers
- Provides a CPU read-back path and independent registered video-side read ports.
- Sits between the CPU (or simulation loader) and the tile/palette renderers.

Parameters:
- GFX_AW, 14, GFX RAM address width (2^14 bytes).
- PAL_AW, 8, palette RAM address width.
- CFG_N, 16, number of configuration registers (fixed at 16; other values unsupported).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- cpu_cen  in  1  bus cycle qualifier; transactions act only when high.
- cpu_addr  in  16  bus address.
- cpu_rnw  in  1  1 = read, 0 = write.
- cpu_dout  in  8  write data from the initiator.
- pal_cs  in  1  palette chip select.
- cpu_din  out  8  read data to the initiator.
- cpu_ok  out  1  one-cycle pulse: cpu_din valid.
- cfg_bus  out  128  config registers, flat; reg n at [8n+7:8n].
- cfg_upd  out  1  one-cycle pulse: a config register changed value.
- vram_addr  in  14  video GFX read address.
- vram_data  out  8  video GFX read data.
- pal_addr  in  8  video palette read address.
- pal_data  out  8  video palette read data.

Behaviour:
- Decode is combinational on the cpu_addr/pal_cs inputs. Priority: palette > GFX > config > unmapped.
  - Palette: pal_cs=1 and cpu_addr[15:8]=8'h0C. Index = cpu_addr[7:0].
  - GFX bank 0: cpu_addr[15:13]=3'b001 (0x2000-0x3FFF). Index = {1'b0, cpu_addr[12:0]}.
  - GFX bank 1: cpu_addr[15:13]=3'b010 (0x4000-0x5FFF). Index = {1'b1, cpu_addr[12:0]}.
  - Config: cpu_addr[15:7]=0, cpu_addr[4:3]=0 and cpu_addr[6:5] in {00,11}. Index = {cpu_addr[6], cpu_addr[2:0]}, so 0x00-0x07 map to regs 0-7 and 0x60-0x67 map to regs 8-15.
  - Any other address is unmapped.
  - pal_cs=1 with an address outside 0x0Cxx falls through to normal decode.
- Write (cpu_cen=1, cpu_rnw=0):
  - The target is updated on that clock edge.
  - Back-to-back writes, one per cycle, are supported with no stalls.
  - Repeated writes to the same location: the last write wins.
  - Unmapped writes are dropped silently.
- cfg_upd:
  - Asserted on the cycle after a config write whose cpu_dout differs from the register's old value.
  - Held low if the value is unchanged.
  - Multiple changing writes in consecutive cycles produce consecutive cfg_upd pulses.
- Read (cpu_cen=1, cpu_rnw=1):
  - cpu_din is registered and is valid on the next cycle. cpu_ok pulses high for exactly that cycle.
  - Unmapped reads return 8'hFF.
  - Config reads return the register value.
  - cpu_din holds its value between reads.
- cpu_cen=0: no write, no read, cpu_ok=0 next cycle.
- Video ports:
  - Synchronous 1-cycle latency, read every cycle, independent of cpu_cen.
  - A CPU write to the same location in the same cycle returns old data (read-before-write). The new data appears on the following read.
- Reset (asynchronous):
  - Clears cfg_bus, cpu_din, cpu_ok, cfg_upd, vram_data and pal_data to 0.
  - RAM contents are not cleared.
  - A transaction in progress when rst asserts is discarded: no pending cpu_ok after release.
  - The first cycle after release accepts transactions normally.

Optional Feature:
- Macro: JTCONTRA_BUSRX_CHK_EN.
- Defined:
  - Internal 16-bit counters gfx_wr_cnt, pal_wr_cnt, cfg_wr_cnt and miss_cnt count accepted writes per target. All saturate at 16'hFFFF and reset to 0.
  - Every unmapped write prints a $display with the address and data.
  - The bench reads the counters hierarchically.
- Undefined: none of this logic exists. Port list and functional behaviour are identical either way.

Test Plan:
- Write 8192 bytes (value = index[7:0]) to 0x2000-0x3FFF, then 8192 bytes to 0x4000-0x5FFF. Sweep vram_addr 0-16383 → vram_data equals the written pattern 1 cycle after each address.
- pal_cs=1, write 0x0C00-0x0CFF with data 8'hFF-index → pal_data matches. Repeat the writes with pal_cs=0 → palette unchanged; with CHK_EN, miss_cnt=256.
- Config writes, in order:
  - 0x0000=8'h12 → cfg_bus[7:0]=8'h12 and cfg_upd=1 next cycle.
  - 0x0000=8'h12 again → cfg_upd stays 0.
  - 0x0067=8'hA5 → cfg_bus[127:120]=8'hA5.
  - 0x0020=8'h33 → dropped.
- Reads:
  - 0x4001 after a write of 8'h5A → cpu_din=8'h5A and a cpu_ok pulse 1 cycle later.
  - 0x8000 → cpu_din=8'hFF.
  - cpu_cen=0 → no cpu_ok.
- Same-cycle CPU write 8'h77 to 0x2010 with vram_addr=14'h0010 (old value 8'h10) → vram_data=8'h10, then 8'h77 on the next cycle.
- Assert rst mid-read (between request and cpu_ok) → cpu_ok, cpu_din and cfg_bus all read 0 after release. RAM data written before reset is still readable.
